ahb_sram_slave: RTL and testbench

- AHB-Lite slave endpoint sitting directly downstream of the AHB interconnect; one instance per slave port.
- Consumes the registered address/control and hwdata the interconnect drives on each slave port.
- Returns hreadyout, hresp and hrdata, which the interconnect routes back to the owning master.
- Word-organised SRAM model with programmable wait states, byte-lane writes and a two-cycle ERROR response.

---
 rtl/ahb_sram_slave.sv | 173 +++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word-organised SRAM slave with byte-lane writes and wait states.
// Latency: data phase completes WAIT_STATES cycles after the address phase. ERROR is always two cycles.
// Backpressure: hreadyout is low during wait states and during the first ERROR cycle.
//
// Ports:
//   hclk, hreset                   clock, asynchronous active-high reset
//   hselx, haddr, htrans, hwrite,  address/control phase from the interconnect
//   hsize, hburst, hprot,          (hburst/hprot/hmastlock are informational only)
//   hmastlock, hready
//   hwdata                         write data, valid in the data phase
//   hreadyout, hresp, hrdata       data-phase response back to the interconnect
//
// Optional feature: define AHB_SRAM_SEQ_NOWAIT_EN so that SEQ beats complete with
// zero wait. Only NONSEQ beats then pay WAIT_STATES. Undefined: every beat waits.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_BITS    = 2,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int WIDX_W = ADDR_WIDTH - SEL_BITS - 2;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;   // a valid, error-free transfer owns the data phase
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       size_q, size_d;
  logic             wr_q, wr_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [WIDX_W-1:0] widx_full_c;
  logic              cap_c;
  logic              err_c;
  logic              ready_c;
  logic              done_c;
  logic [3:0]        wait_ld_c;
  logic [3:0]        be_c;

  // Top SEL_BITS of haddr belong to the interconnect decoder.
  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0],
                       haddr[ADDR_WIDTH-1:ADDR_WIDTH-SEL_BITS]};

  assign widx_full_c = haddr[ADDR_WIDTH-SEL_BITS-1:2];
  assign cap_c       = hselx && hready && htrans[1];

  assign err_c = (widx_full_c >= WIDX_W'(MEM_DEPTH))
              || (hsize > 3'b010)
              || ((hsize == 3'b001) && haddr[0])
              || ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

`ifdef AHB_SRAM_SEQ_NOWAIT_EN
  assign wait_ld_c = (htrans == 2'b11) ? 4'd0 : WS;
`else
  assign wait_ld_c = WS;
`endif

  // Cycles in which the slave drives hreadyout high and may accept a new address.
  assign ready_c = (state_q == S_IDLE) || (state_q == S_ERR2)
                || ((state_q == S_WAIT) && (cnt_q == 4'd0));
  // Completing cycle of an OKAY data phase: write commits / read data is shown.
  assign done_c  = pend_q && ready_c && (state_q != S_ERR2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    widx_d  = widx_q;
    off_d   = off_q;
    size_d  = size_q;
    wr_d    = wr_q;

    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (ready_c) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      if (cap_c) begin
        widx_d = widx_full_c[IDX_W-1:0];
        off_d  = haddr[1:0];
        size_d = hsize;
        wr_d   = hwrite;
        if (err_c) begin
          // Errors skip wait states entirely.
          state_d = S_ERR1;
        end else begin
          pend_d = 1'b1;
          if (wait_ld_c != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = wait_ld_c;
          end
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      widx_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= 3'b000;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      widx_q  <= widx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
    end
  end

  // Little-endian lane enables; alignment was already enforced at capture.
  always_comb begin
    case (size_q)
      3'b000:  be_c = 4'b0001 << off_q;
      3'b001:  be_c = 4'b0011 << off_q;
      default: be_c = 4'b1111;
    endcase
  end

  // Array is not reset. A pending write is dropped by reset because pend_q clears.
  always_ff @(posedge hclk) begin
    if (done_c && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) begin
          mem_q[widx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  assign hreadyout = ready_c;
  assign hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
  // Combinational read after the previous edge's write gives write-then-read forwarding for free.
  assign hrdata    = (done_c && !wr_q) ? mem_q[widx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: cycle-table checks of a zero-wait and a two-wait ahb_sram_slave.
// Latency: one table row per hclk cycle; the row's expected outputs are that cycle's data-phase response.
// Backpressure: each instance's hready is tied to its own hreadyout (single-slave interconnect).
module tb_ahb_sram_slave;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef struct {
    logic        d2;
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel2;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready0, hready2, hreadyout0, hreadyout2;
  logic [1:0]  hresp0, hresp2;
  logic [31:0] hrdata0, hrdata2;

  always #5 hclk = ~hclk;

  assign hready0 = hreadyout0;
  assign hready2 = hreadyout2;

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hselx(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .hmastlock(1'b0),
    .hwdata(hwdata), .hready(hready0), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .hselx(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .hmastlock(1'b0),
    .hwdata(hwdata), .hready(hready2), .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic d2, input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input logic rdy, input logic [1:0] rsp, input logic [31:0] rd);
    vec_t r;
    r.d2 = d2; r.sel = sel; r.tr = tr; r.wr = wr; r.sz = sz; r.addr = a; r.wdata = wd;
    r.e_rdy = rdy; r.e_resp = rsp; r.e_rdata = rd;
    vt.push_back(r);
  endtask

  task automatic set_idle();
    hsel0 = 1'b0; hsel2 = 1'b0; htrans = TI; hwrite = 1'b0; hsize = SW; haddr = '0; hwdata = '0;
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic apply_row(input int i, input vec_t r);
    hsel0  = r.sel & ~r.d2;
    hsel2  = r.sel & r.d2;
    htrans = r.tr; hwrite = r.wr; hsize = r.sz; haddr = r.addr; hwdata = r.wdata;
    @(negedge hclk);
    if (r.d2) begin
      check($sformatf("row%0d dut2 hreadyout", i), hreadyout2, r.e_rdy);
      check($sformatf("row%0d dut2 hresp", i),     hresp2,     r.e_resp);
      check($sformatf("row%0d dut2 hrdata", i),    hrdata2,    r.e_rdata);
    end else begin
      check($sformatf("row%0d dut0 hreadyout", i), hreadyout0, r.e_rdy);
      check($sformatf("row%0d dut0 hresp", i),     hresp0,     r.e_resp);
      check($sformatf("row%0d dut0 hrdata", i),    hrdata0,    r.e_rdata);
    end
    @(posedge hclk); #1;
  endtask

  // NONSEQ word read on the two-wait instance with a bounded wait for completion.
  task automatic read2(input logic [31:0] a, input logic [31:0] exp, input string nm);
    int k;
    k = 0;
    hsel2 = 1'b1; htrans = TN; hwrite = 1'b0; hsize = SW; haddr = a;
    @(posedge hclk); #1;
    hsel2 = 1'b0; htrans = TI;
    while (hreadyout2 !== 1'b1 && k < 20) begin
      @(posedge hclk); #1;
      k++;
    end
    check({nm, " completes"}, hreadyout2, 1'b1);
    check({nm, " hresp"}, hresp2, 2'b00);
    check({nm, " hrdata"}, hrdata2, exp);
    @(posedge hclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_idle();
    hreset = 1'b1;
    #2;
    check("reset dut0 hreadyout", hreadyout0, 1'b1);
    check("reset dut0 hresp",     hresp0,     2'b00);
    check("reset dut0 hrdata",    hrdata0,    32'h0);
    check("reset dut2 hreadyout", hreadyout2, 1'b1);
    check("reset dut2 hresp",     hresp2,     2'b00);
    check("reset dut2 hrdata",    hrdata2,    32'h0);

    // Zero-wait instance: pipelined writes/reads, lanes, errors, ERR2 capture.
    add(0,1,TN,1,SW,32'h04,  32'h0,        1,0,32'h0);
    add(0,1,TN,1,SW,32'h10,  32'h55667788, 1,0,32'h0);
    add(0,1,TN,0,SW,32'h10,  32'hDEADBEEF, 1,0,32'h0);
    add(0,1,TN,1,SW,32'h20,  32'h0,        1,0,32'hDEADBEEF);
    add(0,1,TN,1,SB,32'h21,  32'h11223344, 1,0,32'h0);
    add(0,1,TN,0,SW,32'h20,  32'h0000AA00, 1,0,32'h0);
    add(0,1,TN,1,SH,32'h12,  32'h0,        1,0,32'h1122AA44);
    add(0,1,TN,0,SW,32'h10,  32'hCAFE0000, 1,0,32'h0);
    add(0,1,TN,0,SW,32'h06,  32'h0,        1,0,32'hCAFEBEEF);
    add(0,1,TI,0,SW,32'h0,   32'h0,        0,1,32'h0);
    add(0,1,TN,1,SW,32'h06,  32'h0,        1,1,32'h0);
    add(0,0,TI,0,SW,32'h0,   32'hFFFFFFFF, 0,1,32'h0);
    add(0,1,TN,0,SW,32'h04,  32'hFFFFFFFF, 1,1,32'h0);
    add(0,1,TN,0,SH,32'h13,  32'h0,        1,0,32'h55667788);
    add(0,0,TI,0,SW,32'h0,   32'h0,        0,1,32'h0);
    add(0,1,TN,0,SW,32'h1000,32'h0,        1,1,32'h0);
    add(0,0,TI,0,SW,32'h0,   32'h0,        0,1,32'h0);
    add(0,1,TN,0,SW,32'h20,  32'h0,        1,1,32'h0);
    add(0,1,TN,0,3'b011,32'h20,32'h0,      1,0,32'h1122AA44);
    add(0,1,TB,0,SW,32'h24,  32'h0,        0,1,32'h0);
    add(0,1,TI,0,SW,32'h0,   32'h0,        1,1,32'h0);
    add(0,1,TB,0,SW,32'h0,   32'h0,        1,0,32'h0);
    add(0,1,TN,1,SW,32'hFFC, 32'h0,        1,0,32'h0);
    add(0,1,TN,0,SW,32'hFFC, 32'h0A0B0C0D, 1,0,32'h0);
    add(0,0,TI,0,SW,32'h0,   32'h0,        1,0,32'h0A0B0C0D);

    // Two-wait instance: address held while hreadyout is low.
    add(1,1,TN,1,SW,32'h40,  32'h0,        1,0,32'h0);
    add(1,1,TN,1,SW,32'h40,  32'h12345678, 0,0,32'h0);
    add(1,1,TN,1,SW,32'h40,  32'h12345678, 0,0,32'h0);
    add(1,1,TN,1,SW,32'h44,  32'h12345678, 1,0,32'h0);
    add(1,1,TN,1,SW,32'h44,  32'h9ABCDEF0, 0,0,32'h0);
    add(1,1,TN,1,SW,32'h44,  32'h9ABCDEF0, 0,0,32'h0);
    add(1,1,TN,0,SW,32'h40,  32'h9ABCDEF0, 1,0,32'h0);
    add(1,1,TN,0,SW,32'h40,  32'h0,        0,0,32'h0);
    add(1,1,TN,0,SW,32'h40,  32'h0,        0,0,32'h0);
    add(1,1,TS,0,SW,32'h44,  32'h0,        1,0,32'h12345678);
`ifdef AHB_SRAM_SEQ_NOWAIT_EN
    add(1,1,TN,0,SW,32'h41,  32'h0,        1,0,32'h9ABCDEF0);
`else
    add(1,1,TN,0,SW,32'h41,  32'h0,        0,0,32'h0);
    add(1,1,TN,0,SW,32'h41,  32'h0,        0,0,32'h0);
    add(1,1,TN,0,SW,32'h41,  32'h0,        1,0,32'h9ABCDEF0);
`endif
    add(1,0,TI,0,SW,32'h0,   32'h0,        0,1,32'h0);
    add(1,0,TI,0,SW,32'h0,   32'h0,        1,1,32'h0);
    add(1,0,TI,0,SW,32'h0,   32'h0,        1,0,32'h0);

    @(posedge hclk);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;

    foreach (vt[i]) apply_row(i, vt[i]);

    // Reset in the middle of a write's wait states: write must be dropped.
    set_idle();
    hsel2 = 1'b1; htrans = TN; hwrite = 1'b1; hsize = SW; haddr = 32'h40;
    @(posedge hclk); #1;
    hsel2 = 1'b0; htrans = TI; hwdata = 32'hFFFFFFFF;
    check("wait before reset hreadyout", hreadyout2, 1'b0);
    hreset = 1'b1;
    #1;
    check("reset in wait hreadyout", hreadyout2, 1'b1);
    check("reset in wait hresp",     hresp2,     2'b00);
    check("reset in wait hrdata",    hrdata2,    32'h0);
    @(posedge hclk);
    @(posedge hclk); #1;
    hreset = 1'b0;
    hwdata = 32'h0;
    @(posedge hclk); #1;
    read2(32'h40, 32'h12345678, "dropped write word");
    read2(32'h44, 32'h9ABCDEF0, "retained neighbour word");

    hsel0 = 1'b1; htrans = TN; hwrite = 1'b0; hsize = SW; haddr = 32'h10;
    @(posedge hclk); #1;
    set_idle();
    check("retained dut0 hreadyout", hreadyout0, 1'b1);
    check("retained dut0 hrdata",    hrdata0,    32'hCAFEBEEF);
    @(posedge hclk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
